hyst_seq_ctrl: RTL
==================

# hyst_seq_ctrl

Parametrised sequencing controller for the compute datapath. On a start command it issues a programmable-length run of BRAM read addresses to the compute array and tracks results through a fixed-latency pipeline. It generates matching write-back addresses and enables, and reports completion. The target output bank rotates across a configurable number of banks on each completed run.

## Interface
- ADDR_W, 8, width of read/write addresses; run length up to 2^ADDR_W words
- PIPE_LAT, 2, cycles from rd_en to the matching wr_en; legal range ≥1
- NUM_BANKS, 4, number of output banks; legal range ≥1
- BANK_W, max(1, ceil(log2(NUM_BANKS))), derived width of bank_sel

- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the current run without done
- stall  in  1  hold read issue this edge
- cfg_last  in  ADDR_W  last address of the run (run length = cfg_last+1); captured at accepted start
- rd_en  out  1  read strobe to BRAM/compute (registered)
- rd_addr  out  ADDR_W  read address (registered)
- wr_en  out  1  write-back strobe, = rd_en delayed PIPE_LAT cycles
- wr_addr  out  ADDR_W  write-back address
- bank_sel  out  BANK_W  output bank for the current run
- busy  out  1  high in RUN and DRAIN
- compute_ready  out  1  sticky: first result of the run has been written
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, bank_sel=0, busy=0, compute_ready=0, done=0, valid pipe cleared.
- IDLE: on start=1, capture cfg_last into last_q, clear compute_ready, and set rd_cnt=wr_cnt=0. Go to RUN. start in any other state is ignored.
- Read issue condition, evaluated at the accepting start edge and at every RUN edge: reads remain and stall=0. Effects: rd_en<=1, rd_addr<=rd_cnt, rd_cnt++. If the condition is false, rd_en<=0 and rd_addr holds.
- RUN → DRAIN at the edge that issues address last_q.
- Valid pipe: PIPE_LAT-deep shift register fed by rd_en. It shifts every cycle and is not affected by stall. wr_en = pipe output.
- wr_addr = wr_cnt, which increments after each wr_en cycle. Write order equals read order.
- compute_ready is set at the edge ending the first wr_en cycle of a run. It stays high until the next accepted start or reset.
- DRAIN (or RUN when last_q=0 overlaps) → DONE at the edge ending the wr_en cycle with wr_addr==last_q.
- DONE lasts one cycle with done=1 and busy=0. bank_sel increments, wrapping from NUM_BANKS-1 to 0. Then → IDLE.
- abort=1 in RUN or DRAIN: next edge → IDLE. rd_en=0, valid pipe flushed (no further wr_en), no done, bank_sel unchanged. abort is ignored in IDLE and DONE.
- Precedence: reset > abort > stall. If abort and the final write coincide, abort wins and done is not pulsed.
- Arithmetic: counters are ADDR_W+1 bits internally, so cfg_last = 2^ADDR_W−1 completes without wrap. Address outputs are the low ADDR_W bits.

## Timing
- Cycle 0: start=1 sampled, stall=0. First rd_en is at cycle 1 with rd_addr=0.
- No stalls, N=cfg_last+1:
  - rd_en: cycles 1..N.
  - wr_en: cycles 1+PIPE_LAT..N+PIPE_LAT.
  - busy: cycles 1..N+PIPE_LAT.
  - done: cycle N+PIPE_LAT+1.
  - Earliest next start accepted: cycle N+PIPE_LAT+2.
- Each stalled edge delays all subsequent rd_en, wr_en and done by one cycle. A stall does not create gaps in the valid pipe beyond the missing read.
- compute_ready rises in cycle 2+PIPE_LAT (no stalls).

## Test plan
- Basic run: PIPE_LAT=2, cfg_last=3, start at cycle 0. Required:
  - rd_addr 0,1,2,3 in cycles 1–4.
  - wr_addr 0..3 in cycles 3–6.
  - done in cycle 7, bank_sel 0→1.
  - compute_ready high from cycle 4.
- Stall: cfg_last=3, stall=1 at the edges of cycles 1–2. Required: reads at cycles 1,4,5,6 with addresses 0,1,2,3; wr_en gaps mirror the reads; done in cycle 9.
- Single word, cfg_last=0: one rd_en at cycle 1, one wr_en at cycle 1+PIPE_LAT with wr_addr=0, done the following cycle.
- Bank wrap, NUM_BANKS=3: four back-to-back runs. Required bank_sel sequence 0,1,2,0. start asserted while busy is ignored, with no extra rd_en.
- Abort: assert abort in cycle 2 of a cfg_last=7 run. Required: IDLE next cycle, no wr_en after the abort edge, no done, bank_sel unchanged. A new start then runs normally from address 0.
- Reset mid-DRAIN: all outputs return to their reset values the next cycle, and compute_ready=0. Full length cfg_last=255 (ADDR_W=8) completes with wr_addr reaching 255 and no early done.

Source files
------------

// File: rtl/hyst_seq_ctrl.sv
// Sequencing controller: issues a run of read addresses, tracks them through a
// fixed-latency valid pipe, generates matching write-backs and rotates the output bank.
module hyst_seq_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int PIPE_LAT  = 2,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [ADDR_W-1:0] cfg_last,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BANK_W-1:0] bank_sel,
    output logic              busy,
    output logic              compute_ready,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    last_q, rd_cnt, wr_cnt;
    logic [CNT_W-1:0]    issue_last, issue_cnt;
    logic [PIPE_LAT-1:0] valid_pipe;
    logic [BANK_W-1:0]   bank_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                rd_en_q, ready_q;
    logic                accept, abort_run, issue, final_wr;

    // The accepting start edge issues from the freshly presented cfg_last, not last_q.
    always_comb begin
        accept     = (state == IDLE) && start;
        abort_run  = abort && ((state == RUN) || (state == DRAIN));
        issue_last = accept ? {1'b0, cfg_last} : last_q;
        issue_cnt  = accept ? '0 : rd_cnt;
        issue      = (accept || (state == RUN)) && !abort_run && !stall
                     && (issue_cnt <= issue_last);
        final_wr   = wr_en && (wr_cnt == last_q)
                     && ((state == RUN) || (state == DRAIN));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (issue && (cfg_last == '0)) ? DRAIN : RUN;
            RUN: begin
                if (abort)                              state_nxt = IDLE;
                else if (final_wr)                      state_nxt = DONE;
                else if (issue && (rd_cnt == last_q))   state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)         state_nxt = IDLE;
                else if (final_wr) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            last_q     <= '0;
            valid_pipe <= '0;
            bank_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            rd_en_q <= issue;
            if (issue) begin
                rd_addr_q <= issue_cnt[ADDR_W-1:0];
                rd_cnt    <= issue_cnt + 1'b1;
            end

            if (accept) last_q <= {1'b0, cfg_last};

            // Abort flushes in-flight results so no write-back follows it.
            if (abort_run) valid_pipe <= '0;
            else           valid_pipe <= (valid_pipe << 1) | PIPE_LAT'(rd_en_q);

            if (accept)     wr_cnt <= '0;
            else if (wr_en) wr_cnt <= wr_cnt + 1'b1;

            if (accept)                      ready_q <= 1'b0;
            else if (wr_en && wr_cnt == '0)  ready_q <= 1'b1;

            if (state == DONE)
                bank_q <= (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + 1'b1;
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign wr_en         = valid_pipe[PIPE_LAT-1];
    assign wr_addr       = wr_cnt[ADDR_W-1:0];
    assign bank_sel      = bank_q;
    assign busy          = (state == RUN) || (state == DRAIN);
    assign compute_ready = ready_q;
    assign done          = (state == DONE);

endmodule
